// File: rtl/gray_display_ctrl.sv
// Gray-coded switch bank to binary LED bank plus multiplexed hex 7-segment display,
// with a debounced push-button that toggles a HOLD mode freezing the shown value.
module gray_display_ctrl #(
  parameter int WIDTH           = 8,
  parameter int REFRESH_CYCLES  = 27000,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           gray_i,
  input  logic                       btn_i,
  output logic [WIDTH-1:0]           led_o,
  output logic [6:0]                 seg_o,
  output logic [((WIDTH+3)/4)-1:0]   an_o,
  output logic                       hold_o
);

  localparam int NUM_DIGITS = (WIDTH + 3) / 4;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [WIDTH-1:0]        gray_s1, gray_s2, bin_q, disp_q;
  logic                    btn_s1, btn_s2, btn_db, hold, hold_toggle;
  logic [DW-1:0]           db_cnt;
  logic [RW-1:0]           ref_cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] disp_pad;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   an_d;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_s1 <= '0;
      gray_s2 <= '0;
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      bin_q   <= '0;
    end else begin
      gray_s1 <= gray_i;
      gray_s2 <= gray_s1;
      btn_s1  <= btn_i;
      btn_s2  <= btn_s1;
      bin_q   <= gray2bin(gray_s2);
    end
  end

  // Only an accepted press (debounced rising edge) flips HOLD; releases are ignored.
  assign hold_toggle = (btn_s2 != btn_db) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) && btn_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_s2 == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      btn_db <= btn_s2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // The toggle cycle never loads, so entering HOLD freezes the pre-toggle value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold   <= 1'b0;
      disp_q <= '0;
    end else begin
      if (hold_toggle) hold <= ~hold;
      if (!hold && !hold_toggle) disp_q <= bin_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else if (ref_cnt == RW'(REFRESH_CYCLES - 1)) begin
      ref_cnt <= '0;
      idx     <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  always_comb begin
    disp_pad = '0;
    disp_pad[WIDTH-1:0] = disp_q;
    nibble = 4'h0;
    an_d   = '1;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (idx == IW'(n)) begin
        nibble  = disp_pad[4*n +: 4];
        an_d[n] = 1'b0;
      end
    end
  end

  // Anode and segment registers update together so a digit never shows another digit's pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_o  <= '1;
      seg_o <= SEG_OFF;
    end else begin
      an_o  <= an_d;
      seg_o <= SEG_ACTIVE_LOW ? ~hex_font(nibble) : hex_font(nibble);
    end
  end

  assign led_o  = disp_q;
  assign hold_o = hold;

endmodule

// File: tb/tb_gray_display_ctrl.sv
// Randomized scoreboard bench for gray_display_ctrl: an 8-bit instance with hold/debounce
// exercised and a 5-bit single-cycle-refresh instance for zero-padded top digits.
module tb_gray_display_ctrl;

  typedef struct {
    logic [7:0] val;
    int         lo;
    int         hi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] gray8;
  logic       btn;
  logic [7:0] led8;
  logic [6:0] seg8;
  logic [1:0] an8;
  logic       hold8;
  logic [4:0] gray5;
  logic [4:0] led5;
  logic [6:0] seg5;
  logic [1:0] an5;
  logic       hold5;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   k = 0;
  int   rises = 0;
  exp_t q8[$];
  exp_t q5[$];
  logic [7:0] last8, last5, prev8, prev5;
  logic       prev_hold;
  logic       hold_mode;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  gray_display_ctrl #(.WIDTH(8), .REFRESH_CYCLES(4), .DEBOUNCE_CYCLES(8), .SEG_ACTIVE_LOW(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .gray_i(gray8), .btn_i(btn),
    .led_o(led8), .seg_o(seg8), .an_o(an8), .hold_o(hold8));

  gray_display_ctrl #(.WIDTH(5), .REFRESH_CYCLES(1), .DEBOUNCE_CYCLES(2), .SEG_ACTIVE_LOW(1'b1)) dut5 (
    .clk(clk), .rst_n(rst_n), .gray_i(gray5), .btn_i(1'b0),
    .led_o(led5), .seg_o(seg5), .an_o(an5), .hold_o(hold5));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edges seen since reset released; drives the expected digit-scan position.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // Binary value of a Gray code: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [7:0] gray_to_bin(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    for (int s = 1; s < 8; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [7:0] v, input int d);
    logic [7:0] sh;
    sh = v >> (4 * d);
    return ~font[sh[3:0]];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drives both switch banks and queues the LED values they must produce four edges later.
  task automatic applyStimulus(input logic [7:0] g8, input logic [4:0] g5);
    logic [7:0] b;
    gray8 = g8;
    gray5 = g5;
    b = gray_to_bin(g8);
    if (!hold_mode && b != last8) begin
      q8.push_back('{b, cyc + 4, cyc + 4});
      last8 = b;
    end
    b = gray_to_bin({3'b000, g5});
    if (b != last5) begin
      q5.push_back('{b, cyc + 4, cyc + 4});
      last5 = b;
    end
  endtask

  task automatic press(input int len);
    btn = 1'b1;
    step(len);
    btn = 1'b0;
    step(20);
  endtask

  // Monitor: pops an expectation whenever an LED bank changes, and checks the scan every cycle.
  always @(negedge clk) begin
    exp_t       e;
    int         d8, d5;
    logic [1:0] ea;
    if (!rst_n) begin
      checkOutput("rst_led8", {24'h0, led8}, 32'h0);
      checkOutput("rst_hold", {31'h0, hold8}, 32'h0);
      checkOutput("rst_an8", {30'h0, an8}, 32'h3);
      checkOutput("rst_seg8", {25'h0, seg8}, 32'h7F);
      checkOutput("rst_led5", {27'h0, led5}, 32'h0);
      checkOutput("rst_an5", {30'h0, an5}, 32'h3);
      prev8 = 8'h0;
      prev5 = 8'h0;
      prev_hold = 1'b0;
    end else begin
      if (led8 !== prev8) begin
        if (q8.size() == 0) checkOutput("led8_unexpected", {24'h0, led8}, {24'h0, prev8});
        else begin
          e = q8.pop_front();
          checkOutput("led8_val", {24'h0, led8}, {24'h0, e.val});
          checkOutput("led8_time", (cyc >= e.lo && cyc <= e.hi) ? cyc : -1, cyc);
        end
      end
      if ({3'b000, led5} !== prev5) begin
        if (q5.size() == 0) checkOutput("led5_unexpected", {27'h0, led5}, {24'h0, prev5});
        else begin
          e = q5.pop_front();
          checkOutput("led5_val", {27'h0, led5}, {24'h0, e.val});
          checkOutput("led5_time", (cyc >= e.lo && cyc <= e.hi) ? cyc : -1, cyc);
        end
      end
      if (k >= 1) begin
        d8 = ((k - 1) / 4) % 2;
        ea = ~(2'b01 << d8);
        checkOutput("an8", {30'h0, an8}, {30'h0, ea});
        checkOutput("seg8", {25'h0, seg8}, {25'h0, exp_seg(prev8, d8)});
        d5 = (k - 1) % 2;
        ea = ~(2'b01 << d5);
        checkOutput("an5", {30'h0, an5}, {30'h0, ea});
        checkOutput("seg5", {25'h0, seg5}, {25'h0, exp_seg(prev5, d5)});
      end
      if (hold8 && !prev_hold) rises++;
      prev_hold = hold8;
      prev8 = led8;
      prev5 = {3'b000, led5};
    end
  end

  initial begin
    rst_n = 1'b0;
    gray8 = 8'hFF;
    gray5 = 5'b10000;
    btn = 1'b0;
    last8 = 8'h0;
    last5 = 8'h0;
    hold_mode = 1'b0;
    step(3);
    rst_n = 1'b1;
    applyStimulus(8'hFF, 5'b10000);
    step(8);
    checkOutput("led5_pad", {27'h0, led5}, 32'h1F);

    applyStimulus(8'hC6, 5'b10000);
    step(10);
    checkOutput("led8_c6", {24'h0, led8}, 32'h84);

    for (int i = 0; i < 60; i++) begin
      applyStimulus(8'($urandom), 5'($urandom));
      step($urandom_range(1, 6));
    end
    applyStimulus(8'hC6, 5'($urandom));
    step(10);

    press(5);
    checkOutput("short_press_hold", {31'h0, hold8}, 32'h0);
    press(20);
    checkOutput("long_press_hold", {31'h0, hold8}, 32'h1);
    checkOutput("hold_rises_1", rises, 1);
    hold_mode = 1'b1;
    applyStimulus(8'h01, 5'($urandom));
    step(10);
    checkOutput("held_led8", {24'h0, led8}, 32'h84);

    btn = 1'b1;
    q8.push_back('{8'h01, cyc + 5, cyc + 20});
    last8 = 8'h01;
    hold_mode = 1'b0;
    step(20);
    btn = 1'b0;
    step(20);
    checkOutput("release_hold", {31'h0, hold8}, 32'h0);
    checkOutput("release_led8", {24'h0, led8}, 32'h01);
    checkOutput("hold_rises_still_1", rises, 1);

    press(20);
    checkOutput("rehold", {31'h0, hold8}, 32'h1);
    hold_mode = 1'b1;
    applyStimulus(8'($urandom), 5'($urandom));
    btn = 1'b1;
    step(4);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_hold", {31'h0, hold8}, 32'h0);
    checkOutput("midrst_led8", {24'h0, led8}, 32'h0);
    q8.delete();
    q5.delete();
    btn = 1'b0;
    step(2);
    rst_n = 1'b1;
    last8 = 8'h0;
    last5 = 8'h0;
    hold_mode = 1'b0;
    applyStimulus(gray8, gray5);
    step(20);
    checkOutput("post_rst_hold", {31'h0, hold8}, 32'h0);
    checkOutput("post_rst_led8", {24'h0, led8}, {24'h0, gray_to_bin(gray8)});

    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'($urandom), 5'($urandom));
      step($urandom_range(1, 6));
    end
    for (int i = 0; i < 50 && (q8.size() != 0 || q5.size() != 0); i++) step(1);
    checkOutput("drain_q8", q8.size(), 0);
    checkOutput("drain_q5", q5.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
